// File: rtl/mux_nch_seq.sv
// mux_nch_seq: registered N-channel mux, manual select or auto-scan, valid/ready out.
// Define MUX_NCH_SEQ_PARITY_EN to add the registered even-parity output y_par.
module mux_nch_seq #(
  parameter  int N_CH    = 8,
  parameter  int DATA_W  = 4,
  parameter  int DWELL_W = 8,
  localparam int SEL_W   = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] i,
  input  logic [SEL_W-1:0]       s,
  input  logic                   mode,
  input  logic [DWELL_W-1:0]     dwell,
  input  logic                   en,
  output logic [DATA_W-1:0]      y,
  output logic [SEL_W-1:0]       y_ch,
  output logic                   y_valid,
  input  logic                   y_ready,
`ifdef MUX_NCH_SEQ_PARITY_EN
  output logic                   y_par,
`endif
  output logic                   sel_err
);

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN
  } state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  y_q, y_d;
  logic [SEL_W-1:0]   ych_q, ych_d;
  logic               vld_q, vld_d;
  logic               err_q, err_d;
  logic               src_q, src_d;
  logic               xfer, slot_free, load;
  logic               s_oor, oor;
  logic [SEL_W-1:0]   sel;
  logic [DATA_W-1:0]  chan, ld_data;

  // Selects beyond the last channel only exist when N_CH is not a power of two.
  if (N_CH < (1 << SEL_W)) begin : g_oor
    assign s_oor = (s > LAST);
  end else begin : g_no_oor
    assign s_oor = 1'b0;
  end

  // Channel mux; an out-of-range select yields zero.
  always_comb begin
    chan = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) chan = i[k*DATA_W +: DATA_W];
    end
  end

  // Next state, scan pointer advance and output-slot load decision.
  always_comb begin
    state_d = IDLE;
    if (en) state_d = mode ? SCAN : MANUAL;
    xfer      = vld_q & y_ready;
    slot_free = !vld_q | y_ready;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (xfer && src_q) begin
      if (cnt_q >= dwell) begin
        cnt_d = '0;
        ptr_d = (ptr_q == LAST) ? '0 : ptr_q + SEL_W'(1);
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
    if (state_d == SCAN && state_q != SCAN) begin
      ptr_d = '0;
      cnt_d = '0;
    end
    load    = slot_free && (state_d != IDLE);
    sel     = (state_d == SCAN) ? ptr_d : s;
    oor     = (state_d == MANUAL) && s_oor;
    ld_data = oor ? '0 : chan;
    y_d   = load ? ld_data : y_q;
    ych_d = load ? sel : ych_q;
    err_d = load ? oor : err_q;
    src_d = load ? (state_d == SCAN) : src_q;
    vld_d = load ? 1'b1 : (xfer ? 1'b0 : vld_q);
  end

  // All state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      ych_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      ych_q   <= ych_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      src_q   <= src_d;
    end
  end

`ifdef MUX_NCH_SEQ_PARITY_EN
  logic par_q;

  // Parity tracks y; zero data on out-of-range loads gives zero parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else if (load) par_q <= ^ld_data;
  end

  assign y_par = par_q;
`endif

  assign y       = y_q;
  assign y_ch    = ych_q;
  assign y_valid = vld_q;
  assign sel_err = err_q;

endmodule

// File: tb/tb_mux_nch_seq.sv
// tb_mux_nch_seq: directed plus random stimulus against a behavioural model.
// Runs an 8-channel and a 6-channel instance side by side.
module tb_mux_nch_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic [2:0]  s = '0;
  logic        mode = 1'b0;
  logic [7:0]  dwell = '0;
  logic        en = 1'b0;
  logic        rdy = 1'b0;

  logic [3:0]  y8, y6;
  logic [2:0]  ych8, ych6;
  logic        v8, v6, err8, err6;
`ifdef MUX_NCH_SEQ_PARITY_EN
  logic        par8, par6;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int st;
    int ptr;
    int cnt;
    bit v;
    bit err;
    bit from_scan;
    int y;
    int ych;
    bit par;
  } mdl_t;

  mdl_t m8, m6;

  always #5 clk = ~clk;

  mux_nch_seq #(.N_CH(8), .DATA_W(4), .DWELL_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i(din), .s(s), .mode(mode),
    .dwell(dwell), .en(en), .y(y8), .y_ch(ych8), .y_valid(v8),
    .y_ready(rdy),
`ifdef MUX_NCH_SEQ_PARITY_EN
    .y_par(par8),
`endif
    .sel_err(err8)
  );

  mux_nch_seq #(.N_CH(6), .DATA_W(4), .DWELL_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .i(din[23:0]), .s(s), .mode(mode),
    .dwell(dwell), .en(en), .y(y6), .y_ch(ych6), .y_valid(v6),
    .y_ready(rdy),
`ifdef MUX_NCH_SEQ_PARITY_EN
    .y_par(par6),
`endif
    .sel_err(err6)
  );

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the specified behaviour for an n-channel mux.
  function automatic mdl_t step(mdl_t m, int n, logic [31:0] d,
                                int sv, bit md, int dw, bit e, bit rd);
    mdl_t r;
    int nm;
    int c;
    bit acc;
    r = m;
    nm = !e ? 0 : (md ? 2 : 1);
    acc = m.v && rd;
    if (acc && m.from_scan) begin
      if (m.cnt >= dw) begin
        r.cnt = 0;
        r.ptr = (m.ptr + 1) % n;
      end else begin
        r.cnt = m.cnt + 1;
      end
    end
    if (nm == 2 && m.st != 2) begin
      r.ptr = 0;
      r.cnt = 0;
    end
    if (acc) r.v = 0;
    if (nm != 0 && (!m.v || rd)) begin
      c = (nm == 2) ? r.ptr : sv;
      r.v = 1;
      r.ych = c;
      r.from_scan = (nm == 2);
      r.err = (c >= n);
      r.y = (c >= n) ? 0 : int'((d >> (4 * c)) & 32'hF);
      r.par = ($countones(r.y) % 2) == 1;
    end
    r.st = nm;
    return r;
  endfunction

  task automatic cmp_all();
    chk("y8", int'(y8), m8.y);
    chk("ych8", int'(ych8), m8.ych);
    chk("v8", int'(v8), int'(m8.v));
    chk("err8", int'(err8), int'(m8.err));
    chk("y6", int'(y6), m6.y);
    chk("ych6", int'(ych6), m6.ych);
    chk("v6", int'(v6), int'(m6.v));
    chk("err6", int'(err6), int'(m6.err));
`ifdef MUX_NCH_SEQ_PARITY_EN
    chk("par8", int'(par8), int'(m8.par));
    chk("par6", int'(par6), int'(m6.par));
`endif
  endtask

  task automatic tick();
    mdl_t n8, n6;
    n8 = step(m8, 8, din, int'(s), mode, int'(dwell), en, rdy);
    n6 = step(m6, 6, {8'h0, din[23:0]}, int'(s), mode,
              int'(dwell), en, rdy);
    @(posedge clk);
    m8 = n8;
    m6 = n6;
    @(negedge clk);
    cmp_all();
  endtask

  // Assert reset between edges and check outputs clear without a clock.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y", int'(y8), 0);
    chk("rst_ych", int'(ych8), 0);
    chk("rst_v", int'(v8), 0);
    chk("rst_err", int'(err8), 0);
    chk("rst_v6", int'(v6), 0);
    #1 rst_n = 1'b1;
    m8 = '{default: 0};
    m6 = '{default: 0};
  endtask

  initial begin
    int exp_ch[6];
    int rd_pat[6];
    m8 = '{default: 0};
    m6 = '{default: 0};
    #12;
    chk("por_y", int'(y8), 0);
    chk("por_v", int'(v8), 0);
    chk("por_err6", int'(err6), 0);
    @(negedge clk);
    rst_n = 1'b1;

    din = 32'h0000_0A00;
    s = 3'd2;
    en = 1'b1;
    rdy = 1'b0;
    tick();
    chk("pre_rst_y", int'(y8), 10);
    chk("pre_rst_v", int'(v8), 1);
    mid_reset();

    din = 32'h0C00_5000;
    s = 3'd3;
    rdy = 1'b1;
    tick();
    chk("man_y3", int'(y8), 5);
    chk("man_ch3", int'(ych8), 3);
    s = 3'd6;
    tick();
    chk("man_y6", int'(y8), 12);
    chk("oor_err6", int'(err6), 1);

    s = 3'd3;
    tick();
    rdy = 1'b0;
    repeat (5) begin
      din = $urandom;
      s = 3'($urandom);
      tick();
    end
    chk("stall_y", int'(y8), 5);
    chk("stall_ch", int'(ych8), 3);
    rdy = 1'b1;
    tick();

    din = 32'h7654_3210;
    mode = 1'b1;
    dwell = 8'd1;
    for (int t = 0; t < 18; t++) begin
      tick();
      chk("scan_y", int'(y8), (t / 2) % 8);
      chk("scan_ch", int'(ych8), (t / 2) % 8);
    end

    mode = 1'b0;
    s = 3'd0;
    tick();
    mode = 1'b1;
    dwell = 8'd0;
    rd_pat = '{1, 0, 1, 0, 1, 0};
    exp_ch = '{0, 0, 1, 1, 2, 2};
    for (int t = 0; t < 6; t++) begin
      rdy = rd_pat[t][0];
      tick();
      chk("tog_ch", int'(ych8), exp_ch[t]);
    end

    en = 1'b0;
    rdy = 1'b0;
    tick();
    tick();
    chk("idle_hold_v", int'(v8), 1);
    chk("idle_hold_ch", int'(ych8), 2);
    rdy = 1'b1;
    tick();
    chk("idle_drop_v", int'(v8), 0);
    tick();
    chk("idle_noload", int'(v8), 0);

    en = 1'b1;
    mode = 1'b0;
    din = 32'h0000_0070;
    s = 3'd1;
    tick();
    chk("par_y", int'(y8), 7);
`ifdef MUX_NCH_SEQ_PARITY_EN
    chk("par_bit", int'(par8), 1);
`endif
    s = 3'd7;
    tick();
    chk("oor_y", int'(y6), 0);
    chk("oor_ch", int'(ych6), 7);
    chk("oor_err", int'(err6), 1);
    chk("inr_err8", int'(err8), 0);
    s = 3'd1;
    tick();
    chk("oor_clr", int'(err6), 0);

    for (int t = 0; t < 400; t++) begin
      din = $urandom;
      s = 3'($urandom);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 19) == 0) dwell = 8'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 3) != 0);
      tick();
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_nch_seq.md
Name: mux_nch_seq

Overview:
- Parametrised, registered N-channel multiplexer; successor to the fixed 4:1 single-bit mux family.
- Operates in two modes:
  - manual: select driven by `s`.
  - auto-scan: an internal pointer walks channels 0..N_CH-1 with a programmable dwell.
- Output is a registered sample with valid/ready handshake, plus the channel index it came from. Sits between parallel sensor/data lanes and a single serial consumer.

Parameters:
- N_CH, 8, number of input channels (≥2, need not be a power of two).
- DATA_W, 4, bits per channel.
- DWELL_W, 8, width of the dwell count.
- SEL_W (localparam), $clog2(N_CH), select/pointer width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i  in  N_CH*DATA_W  packed channel data; channel k = i[k*DATA_W +: DATA_W].
- s  in  SEL_W  manual channel select.
- mode  in  1  0 = manual, 1 = auto-scan.
- dwell  in  DWELL_W  scan: accepted samples per channel minus 1.
- en  in  1  enable sampling.
- y  out  DATA_W  registered selected data.
- y_ch  out  SEL_W  channel index of the current y.
- y_valid  out  1  y/y_ch hold a sample.
- y_ready  in  1  consumer accepts the sample when y_valid & y_ready.
- sel_err  out  1  current sample came from an out-of-range manual select.

Behaviour:
- Reset (async, rst_n=0): y=0, y_ch=0, y_valid=0, sel_err=0, ptr=0, dwell_cnt=0, state=IDLE. Release is synchronous to next clk edge.
- FSM states are IDLE, MANUAL and SCAN. Transitions, evaluated each edge:
  - en=0 → IDLE.
  - en=1 & mode=0 → MANUAL.
  - en=1 & mode=1 → SCAN.
  - Any entry into SCAN from another state sets ptr=0 and dwell_cnt=0.
- Slot free = !y_valid | y_ready.
- Load:
  - In MANUAL/SCAN with slot free: y ← channel(sel), y_ch ← sel, y_valid ← 1.
  - sel = s in MANUAL, sel = ptr in SCAN.
  - Latency: input to y is 1 clk.
- Stall: while y_valid & !y_ready, y, y_ch and sel_err are held stable and no load occurs. Changes to i/s/mode are ignored until the slot frees.
- IDLE behaviour:
  - No loads.
  - If y_valid & y_ready, y_valid ← 0.
  - A pending unaccepted sample stays valid until accepted; en=0 never drops a beat.
- Out-of-range (MANUAL, s ≥ N_CH):
  - Loaded y=0, y_ch=s, sel_err=1 with that sample.
  - An in-range load clears sel_err.
- Scan advance:
  - On each accepted transfer (y_valid & y_ready) whose sample came from SCAN:
    - If dwell_cnt == dwell: dwell_cnt ← 0 and ptr ← (ptr==N_CH-1) ? 0 : ptr+1.
    - Else dwell_cnt ← dwell_cnt+1.
  - dwell=0 → one sample per channel.
  - `dwell` is sampled live; a new value lower than dwell_cnt takes effect at the next advance check (compare ==, then wrap via ≥ check: advance if dwell_cnt ≥ dwell).
- Back-to-back: with y_ready held 1, one new sample per clk (full throughput), including across channel advance.
- Mode switch mid-stream:
  - The new mode selects the next load.
  - MANUAL→SCAN restarts at ch0.
  - SCAN→MANUAL leaves ptr frozen (not cleared).

Optional Feature:
- Macro MUX_NCH_SEQ_PARITY_EN.
- Defined:
  - Adds output y_par (1 bit) = even parity (^) of the loaded data, registered with y.
  - Held under stall; reset 0; forced 0 for out-of-range loads.
- Undefined: y_par port and logic absent; all other behaviour identical.

Test Plan (defaults N_CH=8, DATA_W=4):
- Reset mid-stream: y_valid=1, y=4'hA, then rst_n=0 between edges → y=0, y_valid=0, y_ch=0, sel_err=0 immediately, without waiting for a clock edge.
- Manual, y_ready=1, i ch3=4'h5, s=3, en=1 → next clk y=4'h5, y_ch=3, y_valid=1. Change s=6 (ch6=4'hC) → following clk y=4'hC.
- Stall:
  - Loaded y=4'h5; hold y_ready=0 for 5 clk while changing i and s → y/y_ch unchanged.
  - Raise y_ready → transfer, new sample next clk.
- Scan, dwell=1, y_ready=1, ch k data=k → y sequence 0,0,1,1,…,7,7,0,0 with y_ch matching; wrap 7→0 with no bubble.
- Scan, dwell=0, y_ready toggling 1,0,1,0 → ptr advances only on accepted beats; y_ch sequence 0,1,2 with each value held across its stall cycle.
- en=0 while y_valid=1 & y_ready=0 → sample held; y_ready=1 → y_valid=0 next clk; no further loads.
- With N_CH=6 in manual, s=7 → y=0, y_ch=7, sel_err=1. With MUX_NCH_SEQ_PARITY_EN, y=4'b0111 → y_par=1.
